// File: rtl/bit16_serial_subtractor.sv
// bit16_serial_subtractor: nibble-serial 16-bit in1-in2-bw_in; BIT16_SUB_FLAGS_EN enables zero/ovf flags
module bit16_serial_subtractor (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        bw_in,
  output logic        busy,
  output logic        done,
  output logic [16:0] diff,
  output logic        bw_out,
  output logic        zero,
  output logic        ovf
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      r_state, w_state_nxt;
  logic [15:0] r_a, r_b, r_acc;
  logic [1:0]  r_cnt;
  logic        r_borrow, r_done;
  logic [16:0] r_diff;
  logic [3:0]  w_a, w_b, w_g, w_p, w_c, w_dsum;
  logic        w_c4, w_accept, w_last;
  assign w_a = r_a[3:0];
  assign w_b = r_b[3:0];
  assign w_g = w_a & ~w_b;
  assign w_p = ~(w_a ^ w_b);
  assign w_c[0] = ~r_borrow;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c4   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_dsum = w_p ^ w_c;
  assign w_accept = (r_state == IDLE) & start;
  assign w_last   = (r_state == RUN) & (r_cnt == 2'd3);
  // next state: accept from IDLE, return after the fourth digit
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_accept ? RUN : (w_last ? IDLE : r_state);
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end
  // operands rotate so the active digit is always in [3:0]; result shifts in from the top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a      <= in1;
        r_b      <= in2;
        r_cnt    <= '0;
        r_borrow <= bw_in;
      end else if (r_state == RUN) begin
        r_a      <= {r_a[3:0], r_a[15:4]};
        r_b      <= {r_b[3:0], r_b[15:4]};
        r_acc    <= {w_dsum, r_acc[15:4]};
        r_cnt    <= r_cnt + 2'd1;
        r_borrow <= ~w_c4;
        if (w_last) r_diff <= {~w_c4, w_dsum, r_acc[15:4]};
      end
    end
  end
`ifdef BIT16_SUB_FLAGS_EN
  logic r_zero, r_ovf;
  // flags load with the result; on the last digit r_a[3]/r_b[3] hold the original sign bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_zero <= ({w_dsum, r_acc[15:4]} == 16'h0000);
      r_ovf  <= (r_a[3] ^ r_b[3]) & (r_a[3] ^ w_dsum[3]);
    end
  end
  assign zero = r_zero;
  assign ovf  = r_ovf;
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif
  assign busy   = (r_state == RUN);
  assign done   = r_done;
  assign diff   = r_diff;
  assign bw_out = r_diff[16];
endmodule

// File: tb/tb_bit16_serial_subtractor.sv
// tb_bit16_serial_subtractor: directed self-checking bench for the nibble-serial subtractor
module tb_bit16_serial_subtractor;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, bw_in = 1'b0;
  logic [15:0] in1 = '0, in2 = '0;
  logic        busy, done, bw_out, zero, ovf;
  logic [16:0] diff;
  int checks = 0, failures = 0;
`ifdef BIT16_SUB_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  bit16_serial_subtractor dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .bw_in(bw_in),
    .busy(busy), .done(done), .diff(diff), .bw_out(bw_out), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive operands with start, then step over the accepting edge E0
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic bw);
    @(negedge clk);
    in1 = a; in2 = b; bw_in = bw; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_E0", {16'h0, busy}, 17'h1);
    chk("done_after_E0", {16'h0, done}, 17'h0);
  endtask

  // from after E0: E1..E3 busy with diff held, E4 completes
  task automatic finish(input string tag, input logic [16:0] prev, input logic [16:0] ed,
                        input logic ez, input logic eo);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk({tag, "_busy"}, {16'h0, busy}, 17'h1);
      chk({tag, "_held"}, diff, prev);
    end
    @(posedge clk); #1;
    chk({tag, "_done"}, {16'h0, done}, 17'h1);
    chk({tag, "_nbusy"}, {16'h0, busy}, 17'h0);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bw"}, {16'h0, bw_out}, {16'h0, ed[16]});
    chk({tag, "_zero"}, {16'h0, zero}, {16'h0, FL & ez});
    chk({tag, "_ovf"}, {16'h0, ovf}, {16'h0, FL & eo});
  endtask

  task automatic done_drops(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {16'h0, done}, 17'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {16'h0, busy}, 17'h0);
    chk("rst_diff", diff, 17'h0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("idle_done", {16'h0, done}, 17'h0);
    chk("idle_zero_ovf", {15'h0, zero, ovf}, 17'h0);

    launch(16'h1234, 16'h0234, 1'b0);
    finish("t1234", 17'h00000, 17'h01000, 1'b0, 1'b0);
    done_drops("t1234");

    launch(16'h0000, 16'h0001, 1'b0);
    finish("tborrow", 17'h01000, 17'h1FFFF, 1'b0, 1'b0);
    done_drops("tborrow");

    launch(16'h1000, 16'h0000, 1'b1);
    finish("tbwin", 17'h1FFFF, 17'h00FFF, 1'b0, 1'b0);
    done_drops("tbwin");

    launch(16'h8000, 16'h0001, 1'b0);
    finish("tovf", 17'h00FFF, 17'h07FFF, 1'b0, 1'b1);
    done_drops("tovf");

    launch(16'hA5A5, 16'hA5A5, 1'b0);
    finish("tzero", 17'h07FFF, 17'h00000, 1'b1, 1'b0);
    done_drops("tzero");

    // start presented at E2 with different operands must be ignored
    launch(16'h5555, 16'h1111, 1'b0);
    @(posedge clk); #1;
    in1 = 16'hFFFF; in2 = 16'h0000; bw_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy", {16'h0, busy}, 17'h1);
    @(posedge clk); #1;
    chk("ign_busy2", {16'h0, busy}, 17'h1);
    @(posedge clk); #1;
    chk("ign_done", {16'h0, done}, 17'h1);
    chk("ign_diff", diff, 17'h04444);
    @(posedge clk); #1;
    chk("ign_no_restart", {15'h0, busy, done}, 17'h0);

    // start held through done is accepted at E5 with the operands present then
    launch(16'hFFFF, 16'h0001, 1'b0);
    start = 1'b1; in1 = 16'h0010; in2 = 16'h0005; bw_in = 1'b0;
    finish("thold", 17'h04444, 17'h0FFFE, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_E5_busy", {16'h0, busy}, 17'h1);
    chk("hold_E5_done", {16'h0, done}, 17'h0);
    finish("thold2", 17'h0FFFE, 17'h0000B, 1'b0, 1'b0);
    done_drops("thold2");

    // reset at E2 discards the operation
    launch(16'h7777, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_busy", {16'h0, busy}, 17'h0);
    chk("mrst_diff", diff, 17'h0);
    chk("mrst_flags", {14'h0, done, zero, ovf}, 17'h0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_done", {15'h0, busy, done}, 17'h0);
    end
    launch(16'h2000, 16'h0001, 1'b0);
    finish("tafter", 17'h00000, 17'h01FFF, 1'b0, 1'b0);
    done_drops("tafter");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit16_serial_subtractor.md
# bit16_serial_subtractor

Nibble-serial 16-bit subtractor that computes `in1 - in2 - bw_in` over four clock cycles, one 4-bit digit per cycle, with a registered borrow carried between digits. It is the subtract-direction companion to the 16-bit adder datapath. It trades the adder's single-cycle ripple chain for a single shared 4-bit borrow-lookahead slice, a start/done handshake and a held result register. The block sits beside the adder in the arithmetic unit and serves compare, decrement and difference operations where latency is not critical.

## Interface
Parameters: none. Width is fixed at 16 bits, 4 digits of 4 bits.
- `clk`  input  1  single clock; all state updates on the rising edge
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  request; sampled only when `busy`=0
- `in1`  input  16  minuend; captured on the accepting edge
- `in2`  input  16  subtrahend; captured on the accepting edge
- `bw_in`  input  1  borrow-in; captured on the accepting edge
- `busy`  output  1  operation in progress
- `done`  output  1  one-cycle pulse; the result has just been updated
- `diff`  output  17  `{bw_out, difference[15:0]}`; held between operations
- `bw_out`  output  1  final borrow-out; equals `diff[16]`
- `zero`  output  1  the difference equals 0 (see Configuration)
- `ovf`  output  1  signed overflow of the 16-bit difference (see Configuration)

## Operation
- The FSM has two states:
  - IDLE: `busy`=0. If `start`=1 at an edge, latch `in1`, `in2` and `bw_in` into the operand registers, clear the digit counter, set the borrow register to `bw_in`, and go to RUN.
  - RUN: `busy`=1. Each edge processes digit k (bits 4k+3:4k), with k = 0 to 3.
- Per-digit arithmetic: `a + ~b + ~borrow` in 4 bits with lookahead.
  - Generate per bit: `g = a & ~b`. Propagate per bit: `p = ~(a ^ b)`.
  - The digit result goes into the internal shift register.
  - `borrow <= ~carry4`.
- On the edge that processes digit 3:
  - Load `diff` with `{final borrow, assembled difference}`.
  - Update `zero` and `ovf`.
  - Assert `done` for exactly one cycle.
  - Return to IDLE.
- `diff`, `bw_out`, `zero` and `ovf` change only on a completion edge or on reset. They are stable at all other times.
- `start` while `busy`=1 is ignored. It is not queued and does not disturb the current operation.
- Operands may change freely after the accepting edge.
- Signed overflow: `ovf = (in1[15] ^ in2[15]) & (in1[15] ^ diff[15])`, computed on the latched operands.
- Reset at any time, including mid-RUN:
  - All outputs go to 0, the FSM goes to IDLE, and internal registers clear.
  - The interrupted operation is discarded and no `done` is produced.

## Timing
- Accepting edge E0. Digits 0, 1, 2 and 3 are processed at edges E1, E2, E3 and E4.
- `busy` is high from after E0 until E4. `done` and the new `diff` are visible in the cycle after E4.
- Latency is 4 clocks from acceptance to a valid result.
- `start` held high during the `done` cycle is accepted at E5, because the FSM is in IDLE. Peak throughput is one operation per 5 clocks.
- `done` and `busy` are never high in the same cycle.
- Reset values: `busy`=0, `done`=0, `diff`=17'h00000, `bw_out`=0, `zero`=0, `ovf`=0.

## Configuration
- `BIT16_SUB_FLAGS_EN` defined:
  - `zero` and `ovf` are computed and registered as described under Operation.
- `BIT16_SUB_FLAGS_EN` not defined:
  - The flag logic is compiled out.
  - `zero` and `ovf` ports still exist and are tied to 0.
  - `diff`, `bw_out`, handshake behaviour and latency are unchanged.

## Test plan
- `in1`=16'h1234, `in2`=16'h0234, `bw_in`=0, `start` pulse.
  - Response: `busy` for 4 cycles, then `done` for 1 cycle, `diff`=17'h01000, `bw_out`=0, `zero`=0, `ovf`=0.
- `in1`=16'h0000, `in2`=16'h0001, `bw_in`=0.
  - Response: `diff`=17'h1FFFF, `bw_out`=1. Exercises borrow propagation through all 4 digits.
- `in1`=16'h1000, `in2`=16'h0000, `bw_in`=1.
  - Response: `diff`=17'h00FFF.
- `in1`=16'h8000, `in2`=16'h0001.
  - Response: `diff`=17'h07FFF, `ovf`=1 (flags enabled) or 0 (disabled).
- `in1`=`in2`=16'hA5A5.
  - Response: `diff`=0, `zero`=1.
- Second `start` with different operands at E2 of an operation.
  - Required: ignored; the first result is unchanged.
- `start` held high through `done`.
  - Required: the next operation is accepted at E5.
- `rst` asserted at E2 of an operation.
  - Required: all outputs 0 immediately, no `done`.
  - After release, the next operation completes normally.
